instr_decode_fsm: RTL and testbench
===================================

// Module: instr_decode_fsm
// PURPOSE
// Control side of the 16-bit CPU datapath. Holds the instruction register, decodes
// MOV/ADD/CMP/AND/MVN, and sequences the datapath control inputs one step per clock.
// Sits between the instruction source (in/load/s) and datapath; w reports idle.
// PARAMETERS
// DATA_W  16  width of instruction, in, sximm5, sximm8; fixed at 16, must be >= 8
// PORTS
// clk        in   1       rising-edge clock
// reset      in   1       asynchronous, active-high; FSM->WAIT, IR->0
// in         in   DATA_W  instruction word
// load       in   1       capture in into IR at edge; honoured only in WAIT
// s          in   1       start; level-sampled in WAIT
// w          out  1       1 iff state==WAIT
// readnum    out  3       register read select
// writenum   out  3       register write select
// write      out  1       regfile write enable
// loada/loadb/loadc/loads  out  1 each  datapath register enables
// asel       out  1       1 selects A=0
// bsel       out  1       1 selects sximm5; always 0 (no immediate ALU ops)
// ALUop      out  2       ALU function
// shift      out  2       shifter op on B path
// vsel       out  3       regfile input: 000=C, 001=PC, 010=sximm8, 011=mdata; bit2 always 0
// sximm5     out  DATA_W  sign-extended IR[4:0], combinational from IR
// sximm8     out  DATA_W  sign-extended IR[7:0], combinational from IR
// BEHAVIOUR
// - Fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
// - States: WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM.
// - Outputs are Moore (state+IR). Unused outputs drive 0.
// - WAIT: w=1. s=1 -> DECODE, else stay.
// - load in WAIT: IR<=in at that edge.
// - load and s in the same WAIT cycle: DECODE uses the new IR.
// - load outside WAIT: ignored, IR unchanged.
// - DECODE (1 cycle):
//   - 110/10 MOV imm -> WR_IMM.
//   - 110/00 MOV reg -> GET_B.
//   - 101/00 ADD, 101/01 CMP, 101/10 AND -> GET_A.
//   - 101/11 MVN -> GET_B.
//   - any other encoding -> WAIT; no write, no loads.
// - GET_A: readnum=Rn, loada=1 -> GET_B.
// - GET_B: readnum=Rm, loadb=1 -> EXEC.
// - EXEC:
//   - shift=sh, bsel=0.
//   - MOV reg: asel=1, ALUop=00. Otherwise asel=0, ALUop=op.
//   - CMP: loads=1, loadc=0 -> WAIT.
//   - Others: loadc=1 -> WR_REG.
// - WR_REG: writenum=Rd, vsel=000, write=1 -> WAIT.
// - WR_IMM: writenum=Rn, vsel=010, write=1 -> WAIT.
// - Latency counts edges from the edge sampling s=1 to w=1:
//   - MOV imm: 3. MOV reg / MVN: 5. ADD/AND: 6. CMP: 5.
// - s held high across the return to WAIT: w=1 for one cycle, then the next instruction starts.
// - s outside WAIT: ignored.
// - Reset (any time, incl. mid-instruction): immediately w=1, IR=0.
//   - All enables (write, loada/b/c/s), selects, ALUop, shift, vsel, readnum, writenum = 0.
//   - sximm5 = sximm8 = 0.
// TESTING
// - Reset: reset=1 in DECODE -> w=1 and all enables 0 without clock; IR=0.
// - MOV R0,#7: load in=D007 then s=1 -> WR_IMM write=1 writenum=0 vsel=010 sximm8=0007; w=1 after 3 edges.
// - MOV R1,#-2: in=D1FE -> sximm8=FFFE; sximm5=FFFE; write in WR_IMM with writenum=1.
// - ADD R2,R1,R0,LSL#1: in=A148 -> 6-edge sequence:
//   - GET_A readnum=1 loada=1.
//   - GET_B readnum=0 loadb=1.
//   - EXEC ALUop=00 shift=01 asel=0 loadc=1.
//   - WR_REG writenum=2 vsel=000 write=1.
// - CMP R1,R0: in=A900 -> EXEC loads=1 ALUop=01 loadc=0; write never 1; w=1 after 5 edges.
// - MVN R3,R0 (in=B860) with load=1 in=D007 during GET_B -> IR stays B860; EXEC ALUop=11; WR_REG writenum=3.

Source files
------------

// File: rtl/instr_decode_if.sv
// Instruction-source / datapath-control bundle for instr_decode_fsm.
// The master drives instructions (in/load/s); the slave (decoder) drives the datapath controls.
interface instr_decode_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] in;
    logic              load;
    logic              s;
    logic              w;
    logic [2:0]        readnum;
    logic [2:0]        writenum;
    logic              write;
    logic              loada;
    logic              loadb;
    logic              loadc;
    logic              loads;
    logic              asel;
    logic              bsel;
    logic [1:0]        ALUop;
    logic [1:0]        shift;
    logic [2:0]        vsel;
    logic [DATA_W-1:0] sximm5;
    logic [DATA_W-1:0] sximm8;

    modport master (
        output in, load, s,
        input  w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, ALUop, shift, vsel, sximm5, sximm8
    );

    modport slave (
        input  in, load, s,
        output w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, ALUop, shift, vsel, sximm5, sximm8
    );
endinterface

// File: rtl/instr_decode_fsm.sv
// Instruction register and control sequencer for the 16-bit CPU datapath.
// Decodes MOV/ADD/CMP/AND/MVN and steps the datapath one control phase per clock.
//
// state    | meaning
// WAIT     | idle, w=1; IR loadable, s starts the instruction
// DECODE   | one cycle to classify IR
// GET_A    | read Rn into A
// GET_B    | read Rm into B
// EXEC     | ALU/shifter operation; C or status register captured
// WR_REG   | write C into Rd
// WR_IMM   | write sximm8 into Rn
module instr_decode_fsm #(
    parameter int DATA_W = 16
) (
    input logic           clk,
    input logic           reset,
    instr_decode_if.slave bus
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_REG,
        S_WR_IMM
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;

    assign opcode = ir_q[15:13];
    assign op     = ir_q[12:11];
    assign rn     = ir_q[10:8];
    assign rd     = ir_q[7:5];
    assign sh     = ir_q[4:3];
    assign rm     = ir_q[2:0];

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_alu;
    logic is_cmp;
    logic is_mvn;
    logic needs_a;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign needs_a    = is_alu && !is_mvn;

    // IR is only writable while idle so an in-flight instruction never changes under the datapath.
    always_comb begin
        ir_d = ir_q;
        if (state_q == S_WAIT && bus.load) begin
            ir_d = bus.in;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (bus.s) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mov_imm) begin
                    state_d = S_WR_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    state_d = S_GET_B;
                end else if (needs_a) begin
                    state_d = S_GET_A;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_EXEC;
            S_EXEC:   state_d = is_cmp ? S_WAIT : S_WR_REG;
            S_WR_REG: state_d = S_WAIT;
            S_WR_IMM: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    logic       w_d;
    logic [2:0] readnum_d;
    logic [2:0] writenum_d;
    logic       write_d;
    logic       loada_d;
    logic       loadb_d;
    logic       loadc_d;
    logic       loads_d;
    logic       asel_d;
    logic       bsel_d;
    logic [1:0] aluop_d;
    logic [1:0] shift_d;
    logic [2:0] vsel_d;

    // Moore outputs: decoded from the current state and IR only.
    always_comb begin
        w_d        = 1'b0;
        readnum_d  = 3'b000;
        writenum_d = 3'b000;
        write_d    = 1'b0;
        loada_d    = 1'b0;
        loadb_d    = 1'b0;
        loadc_d    = 1'b0;
        loads_d    = 1'b0;
        asel_d     = 1'b0;
        bsel_d     = 1'b0;
        aluop_d    = 2'b00;
        shift_d    = 2'b00;
        vsel_d     = 3'b000;
        case (state_q)
            S_WAIT: begin
                w_d = 1'b1;
            end
            S_GET_A: begin
                readnum_d = rn;
                loada_d   = 1'b1;
            end
            S_GET_B: begin
                readnum_d = rm;
                loadb_d   = 1'b1;
            end
            S_EXEC: begin
                shift_d = sh;
                if (is_mov_reg) begin
                    asel_d  = 1'b1;
                    aluop_d = 2'b00;
                end else begin
                    aluop_d = op;
                end
                if (is_cmp) begin
                    loads_d = 1'b1;
                end else begin
                    loadc_d = 1'b1;
                end
            end
            S_WR_REG: begin
                writenum_d = rd;
                vsel_d     = 3'b000;
                write_d    = 1'b1;
            end
            S_WR_IMM: begin
                writenum_d = rn;
                vsel_d     = 3'b010;
                write_d    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.w        = w_d;
    assign bus.readnum  = readnum_d;
    assign bus.writenum = writenum_d;
    assign bus.write    = write_d;
    assign bus.loada    = loada_d;
    assign bus.loadb    = loadb_d;
    assign bus.loadc    = loadc_d;
    assign bus.loads    = loads_d;
    assign bus.asel     = asel_d;
    assign bus.bsel     = bsel_d;
    assign bus.ALUop    = aluop_d;
    assign bus.shift    = shift_d;
    assign bus.vsel     = vsel_d;
    assign bus.sximm5   = {{(DATA_W-5){ir_q[4]}}, ir_q[4:0]};
    assign bus.sximm8   = {{(DATA_W-8){ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_instr_decode_fsm.sv
// Self-checking bench for instr_decode_fsm: per-cycle control snapshots from a
// table of instructions via an expectation queue, plus hand-written corner sequences.
module tb_instr_decode_fsm;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_decode_if #(.DATA_W(DATA_W)) bus ();

    instr_decode_fsm #(.DATA_W(DATA_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] aluop;
        logic [1:0] shift;
        logic [2:0] vsel;
    } outs_t;

    typedef enum logic [1:0] {K_IMM, K_A, K_B, K_BAD} kind_t;

    typedef struct packed {
        logic [15:0] instr;
        kind_t       kind;
        logic [2:0]  rn;
        logic [2:0]  rm;
        logic [2:0]  rd;
        logic [1:0]  sh;
        logic [1:0]  aluop;
        logic        asel;
        logic        cmp;
        logic [15:0] sx5;
        logic [15:0] sx8;
        logic [3:0]  lat;
    } vec_t;

    localparam int NVEC = 9;
    vec_t  vecs [NVEC];
    outs_t exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic outs_t sample();
        outs_t o;
        o.w        = bus.w;
        o.readnum  = bus.readnum;
        o.writenum = bus.writenum;
        o.write    = bus.write;
        o.loada    = bus.loada;
        o.loadb    = bus.loadb;
        o.loadc    = bus.loadc;
        o.loads    = bus.loads;
        o.asel     = bus.asel;
        o.bsel     = bus.bsel;
        o.aluop    = bus.ALUop;
        o.shift    = bus.shift;
        o.vsel     = bus.vsel;
        return o;
    endfunction

    task automatic check_outs(input string name, input outs_t exp);
        outs_t act;
        act = sample();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: controls got %b expected %b (w rn wn wr la lb lc ls as bs alu sh vs)",
                     name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected control snapshot after each clock edge, from the edge that samples s=1.
    task automatic push_expected(input vec_t v);
        outs_t o;
        o = '0;
        exp_q.push_back(o);
        case (v.kind)
            K_IMM: begin
                o = '0; o.writenum = v.rn; o.write = 1'b1; o.vsel = 3'b010;
                exp_q.push_back(o);
            end
            K_A, K_B: begin
                if (v.kind == K_A) begin
                    o = '0; o.readnum = v.rn; o.loada = 1'b1;
                    exp_q.push_back(o);
                end
                o = '0; o.readnum = v.rm; o.loadb = 1'b1;
                exp_q.push_back(o);
                o = '0; o.shift = v.sh; o.asel = v.asel; o.aluop = v.aluop;
                if (v.cmp) o.loads = 1'b1;
                else       o.loadc = 1'b1;
                exp_q.push_back(o);
                if (!v.cmp) begin
                    o = '0; o.writenum = v.rd; o.write = 1'b1;
                    exp_q.push_back(o);
                end
            end
            default: begin
            end
        endcase
        o = '0; o.w = 1'b1;
        exp_q.push_back(o);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        outs_t exp;
        int    edges;
        int    got_lat;
        @(negedge clk);
        bus.in   = v.instr;
        bus.load = 1'b1;
        bus.s    = 1'b1;
        push_expected(v);
        @(posedge clk); #1;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        check_val($sformatf("v%0d sximm5", idx), {16'h0, bus.sximm5}, {16'h0, v.sx5});
        check_val($sformatf("v%0d sximm8", idx), {16'h0, bus.sximm8}, {16'h0, v.sx8});
        edges   = 1;
        got_lat = 0;
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            if (bus.w === 1'b1 && got_lat == 0) got_lat = edges;
            check_outs($sformatf("v%0d edge%0d", idx, edges), exp);
            if (exp_q.size() > 0) begin
                @(posedge clk); #1;
                edges++;
            end
        end
        check_val($sformatf("v%0d latency", idx), got_lat, {28'h0, v.lat});
    endtask

    initial begin
        outs_t o;
        int    k;

        vecs[0] = '{instr:16'hD007, kind:K_IMM, rn:3'd0, rm:3'd0, rd:3'd0, sh:2'd0, aluop:2'd0,
                    asel:1'b0, cmp:1'b0, sx5:16'h0007, sx8:16'h0007, lat:4'd3};
        vecs[1] = '{instr:16'hD1FE, kind:K_IMM, rn:3'd1, rm:3'd6, rd:3'd7, sh:2'd3, aluop:2'd0,
                    asel:1'b0, cmp:1'b0, sx5:16'hFFFE, sx8:16'hFFFE, lat:4'd3};
        vecs[2] = '{instr:16'hA148, kind:K_A, rn:3'd1, rm:3'd0, rd:3'd2, sh:2'd1, aluop:2'd0,
                    asel:1'b0, cmp:1'b0, sx5:16'h0008, sx8:16'h0048, lat:4'd6};
        vecs[3] = '{instr:16'hA900, kind:K_A, rn:3'd1, rm:3'd0, rd:3'd0, sh:2'd0, aluop:2'd1,
                    asel:1'b0, cmp:1'b1, sx5:16'h0000, sx8:16'h0000, lat:4'd5};
        vecs[4] = '{instr:16'hB293, kind:K_A, rn:3'd2, rm:3'd3, rd:3'd4, sh:2'd2, aluop:2'd2,
                    asel:1'b0, cmp:1'b0, sx5:16'hFFF3, sx8:16'hFF93, lat:4'd6};
        vecs[5] = '{instr:16'hC0BE, kind:K_B, rn:3'd0, rm:3'd6, rd:3'd5, sh:2'd3, aluop:2'd0,
                    asel:1'b1, cmp:1'b0, sx5:16'hFFFE, sx8:16'hFFBE, lat:4'd5};
        vecs[6] = '{instr:16'hB860, kind:K_B, rn:3'd0, rm:3'd0, rd:3'd3, sh:2'd0, aluop:2'd3,
                    asel:1'b0, cmp:1'b0, sx5:16'h0000, sx8:16'h0060, lat:4'd5};
        vecs[7] = '{instr:16'hE000, kind:K_BAD, rn:3'd0, rm:3'd0, rd:3'd0, sh:2'd0, aluop:2'd0,
                    asel:1'b0, cmp:1'b0, sx5:16'h0000, sx8:16'h0000, lat:4'd2};
        vecs[8] = '{instr:16'hC8F1, kind:K_BAD, rn:3'd0, rm:3'd1, rd:3'd7, sh:2'd2, aluop:2'd0,
                    asel:1'b0, cmp:1'b0, sx5:16'hFFF1, sx8:16'hFFF1, lat:4'd2};

        bus.in   = '0;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        reset    = 1'b1;
        #3;
        o = '0; o.w = 1'b1;
        check_outs("reset idle", o);
        check_val("reset sximm8", {16'h0, bus.sximm8}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset mid-instruction: takes effect without a clock edge.
        @(negedge clk);
        bus.in = 16'hD1FE; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0; bus.s = 1'b0;
        check_val("decode w", {31'h0, bus.w}, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        o = '0; o.w = 1'b1;
        check_outs("async reset controls", o);
        check_val("async reset sximm8", {16'h0, bus.sximm8}, 32'h0);
        check_val("async reset sximm5", {16'h0, bus.sximm5}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check_outs("idle after reset", o);

        // MVN with a load attempt during GET_B: IR must hold.
        @(negedge clk);
        bus.in = 16'hB860; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0; bus.s = 1'b0;
        @(posedge clk); #1;
        o = '0; o.loadb = 1'b1; o.readnum = 3'd0;
        check_outs("mvn get_b", o);
        bus.in = 16'hD007; bus.load = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        o = '0; o.aluop = 2'b11; o.loadc = 1'b1;
        check_outs("mvn exec", o);
        check_val("ir held sximm8", {16'h0, bus.sximm8}, 32'h0000_0060);
        @(posedge clk); #1;
        o = '0; o.writenum = 3'd3; o.write = 1'b1;
        check_outs("mvn wr_reg", o);
        @(posedge clk); #1;
        check_val("mvn done w", {31'h0, bus.w}, 32'h1);

        // s held high across the return to WAIT restarts after one idle cycle.
        @(negedge clk);
        bus.in = 16'hD007; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("s held w at edge3", {31'h0, bus.w}, 32'h1);
        @(posedge clk); #1;
        check_val("s held restart w", {31'h0, bus.w}, 32'h0);
        check_val("s held sximm8", {16'h0, bus.sximm8}, 32'h0000_0007);
        bus.s = 1'b0;
        k = 0;
        while (bus.w !== 1'b1 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        check_val("restart completes in 2", k, 32'd2);

        // load in WAIT without s: IR updates, stays idle.
        @(negedge clk);
        bus.in = 16'hC0BE; bus.load = 1'b1; bus.s = 1'b0;
        @(posedge clk); #1;
        bus.load = 1'b0;
        check_val("load only sximm8", {16'h0, bus.sximm8}, 32'h0000_FFBE);
        @(posedge clk); #1;
        o = '0; o.w = 1'b1;
        check_outs("load only idle", o);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
